flash_ctrl_v2: RTL
==================

Name: flash_ctrl_v2

Overview:
Parametrised successor of the accelerator's flash/MapROM controller. Decodes 68000 bus cycles into flash read/write windows and inserts programmable wait states. Generates timed WE pulses with setup/hold and an optional busy-wait. Adds a CPU-writable control register for flash bank paging and write unlock. Sits between the CPU bus (CLKCPU domain) and the parallel NOR flash.

Parameters:
BANK_BITS, 2, width of bank register; flash upper address = {bank, A19-select}
WS_FAST, 0, read wait states when SPEED_SLOW=0
WS_SLOW, 3, read wait states when SPEED_SLOW=1
WE_SETUP, 1, CLKCPU cycles, address/data valid before WE falls
WE_WIDTH, 2, CLKCPU cycles, WE low
WE_HOLD, 1, CLKCPU cycles, WE high before DTACK
CTRL_PAGE, 8'hE9, A[23:16] of control register
CNT_W, 4, timer width; all timing params must be < 2**CNT_W (elaboration error otherwise)

Ports:
CLKCPU  in  1  CPU clock; all state on rising edge
RESET_n  in  1  asynchronous, active-low reset
A  in  23 [23:1]  CPU address
AS_CPU_n  in  1  address strobe, sampled on CLKCPU
DS_n  in  1  combined data strobe (low = either byte lane)
RW_n  in  1  1=read, 0=write
D_HI  in  8  CPU data D[15:8], control-register write data
MAPROM_DIS  in  1  static strap; 1 = MapROM disabled
SPEED_SLOW  in  1  1 = selects WS_SLOW
FLASH_BUSY_n  in  1  flash ready/busy
FLASH_ACCESS  out  1  combinational window decode
FLASH_HI  out  BANK_BITS+1  flash upper address bits
FLASH_RESET_n  out  1  = RESET_n
FLASH_OE_n  out  1  registered
FLASH_WE_n  out  1  registered
DTACK_n  out  1  registered
OVL  out  1  boot overlay active

Behaviour:
- Reset (RESET_n low, async): FSM=IDLE, FLASH_OE_n=1, FLASH_WE_n=1, DTACK_n=1, OVL=1, bank=0, unlock=0, timer=0.
- maprom = !MAPROM_DIS. Windows (FLASH_ACCESS): PROG A[23:20]=4'hA && !maprom; OVLW A[23:20]=0 && maprom && OVL; ROMF A[23:19]=5'b11111 && maprom; ROME A[23:19]=5'b11100 && maprom && !AS_CPU_n.
- FLASH_HI: PROG -> {bank, A[19]}; other windows -> {0, A[19]|OVL}.
- OVL cleared on any edge with !AS_CPU_n && !RW_n && A[23:16]=8'hBF; set only by reset.
- Control register: write cycle with A[23:16]=CTRL_PAGE, !DS_n: bank<=D_HI[BANK_BITS-1:0], unlock<=D_HI[7]; DTACK_n low same edge. Reads of this page: DTACK_n low, data not driven by this block.
- FSM states: IDLE, RWAIT, WSETUP, WPULSE, WHOLD, WBUSY, ACK.
- IDLE, edge with !AS_CPU_n && FLASH_ACCESS:
  - Read: OE_n<=0. WS=SPEED_SLOW?WS_SLOW:WS_FAST. WS=0 -> ACK, DTACK_n<=0 on this edge. Else RWAIT, timer counts WS edges, then DTACK_n<=0.
  - Write, !DS_n, PROG window, unlock=1 -> WSETUP.
  - Write otherwise (locked, MapROM window) -> ACK immediately; no WE pulse; data discarded.
  - Write with DS_n still high -> stay IDLE until DS_n low.
- WSETUP: WE_SETUP edges, WE_n=1 -> WPULSE (WE_n<=0 on entry) for WE_WIDTH edges -> WHOLD (WE_n<=1) for WE_HOLD edges -> ACK (or WBUSY, see option). A zero-valued phase is skipped.
- ACK: DTACK_n=0 held until AS_CPU_n sampled high.
- Any state, edge with AS_CPU_n high: next state IDLE, OE_n=WE_n=DTACK_n=1, timer=0. This edge aborts a WE pulse mid-flight; WE_n rises on that edge.
- Non-flash, non-control cycles: DTACK_n stays 1.
- Timer: CNT_W bits, reloaded on each state entry, never wraps.

Optional Feature:
FLASH_BUSY_WAIT_EN defined: WHOLD -> WBUSY. WBUSY holds DTACK_n=1 until FLASH_BUSY_n sampled high, then -> ACK. AS_CPU_n high still aborts.
Undefined: WHOLD -> ACK. FLASH_BUSY_n ignored. Software polls status.

Decomposition:
- Package flash_pkg: state enum, window decode constants (4'hA, 5'b11111, 5'b11100, 8'hBF), control bit index UNLOCK_BIT=7.
- One sub-module flash_we_timer: three-phase setup/pulse/hold down-counter with start/abort/done ports.

Test Plan:
- Read $F80000, maprom=1, SPEED_SLOW=1, WS_SLOW=3 -> OE_n low edge 0, DTACK_n low edge 3, both high one edge after AS_n rises.
- After reset, read $000004 -> FLASH_ACCESS=1, FLASH_HI=3'b001. Write $BFE001 -> OVL=0, FLASH_ACCESS for $000004 becomes 0.
- MAPROM_DIS=1, write 8'h82 to $E90000, then write $A80000 -> FLASH_HI=3'b101. WE_n high 1 edge, low 2 edges, high 1 edge, then DTACK_n low.
- Same write with unlock=0 -> WE_n never falls, DTACK_n low edge 0.
- AS_n rises during WPULSE -> WE_n high on that edge, FSM IDLE, DTACK_n never asserted.
- FLASH_BUSY_WAIT_EN, FLASH_BUSY_n low 10 cycles after WHOLD -> DTACK_n low exactly 1 edge after FLASH_BUSY_n sampled high.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and decode constants for the flash/MapROM controller.
package flash_pkg;

  // Bus-side controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RWAIT,
    ST_WSETUP,
    ST_WPULSE,
    ST_WHOLD,
    ST_WBUSY,
    ST_ACK
  } state_e;

  // Write-strobe timer phases
  typedef enum logic [1:0] {
    WT_IDLE,
    WT_SETUP,
    WT_PULSE,
    WT_HOLD
  } we_phase_e;

  localparam logic [3:0] PROG_NIB     = 4'hA;      // A[23:20] of the programming window
  localparam logic [4:0] ROMF_SEL     = 5'b11111;  // A[23:19] of the $F8 ROM window
  localparam logic [4:0] ROME_SEL     = 5'b11100;  // A[23:19] of the $E0 ROM window
  localparam logic [7:0] OVL_CLR_PAGE = 8'hBF;     // CIA page whose write drops the overlay
  localparam int unsigned UNLOCK_BIT  = 7;         // control register write-unlock bit

  // Maps the write timer phase onto the matching controller state
  function automatic state_e phase_state(input we_phase_e p);
    case (p)
      WT_SETUP: return ST_WSETUP;
      WT_PULSE: return ST_WPULSE;
      WT_HOLD:  return ST_WHOLD;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/flash_we_timer.sv
// Three-phase (setup / pulse / hold) write-strobe sequencer for the NOR flash.
// Each phase lasts its parameter's worth of clock edges; zero-length phases are
// skipped. phase_nxt and done are combinational so the owning FSM can follow
// the sequence on the same edge.
module flash_we_timer
  import flash_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned WE_SETUP = 1,
  parameter int unsigned WE_WIDTH = 2,
  parameter int unsigned WE_HOLD  = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  logic      abort,
  output we_phase_e phase_nxt,
  output logic      done,
  output logic      we_n
);

  localparam logic [CNT_W-1:0] LEN_S = CNT_W'(WE_SETUP);
  localparam logic [CNT_W-1:0] LEN_P = CNT_W'(WE_WIDTH);
  localparam logic [CNT_W-1:0] LEN_H = CNT_W'(WE_HOLD);

  we_phase_e        phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             seek;
  logic [1:0]       from;

  // Phase and counter registers; WE is low exactly while in the pulse phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= WT_IDLE;
      cnt   <= '0;
      we_n  <= 1'b1;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      we_n  <= (phase_nxt != WT_PULSE);
    end
  end

  // Next phase: count down, then search forward for the next non-empty phase.
  // The search is written latest-first so the earliest eligible phase wins.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    done      = 1'b0;
    seek      = 1'b0;
    from      = 2'd0;
    if (abort) begin
      phase_nxt = WT_IDLE;
      cnt_nxt   = '0;
    end else if (phase == WT_IDLE) begin
      seek = start;
    end else if (cnt == '0) begin
      seek = 1'b1;
      case (phase)
        WT_SETUP: from = 2'd1;
        WT_PULSE: from = 2'd2;
        default:  from = 2'd3;
      endcase
    end else begin
      cnt_nxt = cnt - 1'b1;
    end

    if (seek) begin
      phase_nxt = WT_IDLE;
      cnt_nxt   = '0;
      done      = 1'b1;
      if (from <= 2'd2 && LEN_H != '0) begin
        phase_nxt = WT_HOLD;
        cnt_nxt   = LEN_H - 1'b1;
        done      = 1'b0;
      end
      if (from <= 2'd1 && LEN_P != '0) begin
        phase_nxt = WT_PULSE;
        cnt_nxt   = LEN_P - 1'b1;
        done      = 1'b0;
      end
      if (from == 2'd0 && LEN_S != '0) begin
        phase_nxt = WT_SETUP;
        cnt_nxt   = LEN_S - 1'b1;
        done      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/flash_ctrl_v2.sv
// Flash / MapROM controller: decodes 68000 bus cycles into flash windows,
// inserts read wait states, sequences timed WE pulses and hosts the bank /
// unlock control register. Optional macro FLASH_BUSY_WAIT_EN adds a wait on
// FLASH_BUSY_n after the WE hold phase.
module flash_ctrl_v2
  import flash_pkg::*;
#(
  parameter int unsigned BANK_BITS = 2,
  parameter int unsigned WS_FAST   = 0,
  parameter int unsigned WS_SLOW   = 3,
  parameter int unsigned WE_SETUP  = 1,
  parameter int unsigned WE_WIDTH  = 2,
  parameter int unsigned WE_HOLD   = 1,
  parameter logic [7:0]  CTRL_PAGE = 8'hE9,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 CLKCPU,
  input  logic                 RESET_n,
  input  logic [23:1]          A,
  input  logic                 AS_CPU_n,
  input  logic                 DS_n,
  input  logic                 RW_n,
  input  logic [7:0]           D_HI,
  input  logic                 MAPROM_DIS,
  input  logic                 SPEED_SLOW,
  input  logic                 FLASH_BUSY_n,
  output logic                 FLASH_ACCESS,
  output logic [BANK_BITS:0]   FLASH_HI,
  output logic                 FLASH_RESET_n,
  output logic                 FLASH_OE_n,
  output logic                 FLASH_WE_n,
  output logic                 DTACK_n,
  output logic                 OVL
);

  if (WS_FAST >= 2**CNT_W || WS_SLOW >= 2**CNT_W || WE_SETUP >= 2**CNT_W ||
      WE_WIDTH >= 2**CNT_W || WE_HOLD >= 2**CNT_W) begin : g_bad_timing
    $error("flash_ctrl_v2: timing parameter does not fit in CNT_W bits");
  end
  if (BANK_BITS > UNLOCK_BIT) begin : g_bad_bank
    $error("flash_ctrl_v2: BANK_BITS overlaps the unlock bit");
  end

`ifdef FLASH_BUSY_WAIT_EN
  localparam state_e AFTER_HOLD = ST_WBUSY;
`else
  localparam state_e AFTER_HOLD = ST_ACK;
`endif

  state_e               state;
  state_e               state_nxt;
  logic [CNT_W-1:0]     timer;
  logic [CNT_W-1:0]     timer_nxt;
  logic [CNT_W-1:0]     ws;
  logic                 oe_n;
  logic                 oe_n_nxt;
  logic                 dtack_n;
  logic                 dtack_n_nxt;
  logic                 ovl;
  logic [BANK_BITS-1:0] bank;
  logic                 unlock;
  logic                 maprom;
  logic                 win_prog;
  logic                 win_ovl;
  logic                 win_romf;
  logic                 win_rome;
  logic                 ctrl_hit;
  logic                 we_start;
  we_phase_e            wt_phase_nxt;
  logic                 wt_done;
  state_e               we_follow;
  logic                 sig_unused;

  // Address bits below the page and spare data bits play no part in decode
  assign sig_unused = ^{A[15:1], D_HI[UNLOCK_BIT-1:BANK_BITS], FLASH_BUSY_n};

  assign maprom   = !MAPROM_DIS;
  assign win_prog = (A[23:20] == PROG_NIB) && !maprom;
  assign win_ovl  = (A[23:20] == 4'h0) && maprom && ovl;
  assign win_romf = (A[23:19] == ROMF_SEL) && maprom;
  assign win_rome = (A[23:19] == ROME_SEL) && maprom && !AS_CPU_n;
  assign ctrl_hit = (A[23:16] == CTRL_PAGE);

  assign FLASH_ACCESS  = win_prog || win_ovl || win_romf || win_rome;
  assign FLASH_HI      = win_prog ? {bank, A[19]} : {{BANK_BITS{1'b0}}, A[19] | ovl};
  assign FLASH_RESET_n = RESET_n;
  assign FLASH_OE_n    = oe_n;
  assign DTACK_n       = dtack_n;
  assign OVL           = ovl;

  assign ws       = SPEED_SLOW ? CNT_W'(WS_SLOW) : CNT_W'(WS_FAST);
  assign we_start = (state == ST_IDLE) && !AS_CPU_n && !ctrl_hit && FLASH_ACCESS &&
                    !RW_n && !DS_n && win_prog && unlock;

  flash_we_timer #(
    .CNT_W    (CNT_W),
    .WE_SETUP (WE_SETUP),
    .WE_WIDTH (WE_WIDTH),
    .WE_HOLD  (WE_HOLD)
  ) u_we_timer (
    .clk       (CLKCPU),
    .rst_n     (RESET_n),
    .start     (we_start),
    .abort     (AS_CPU_n),
    .phase_nxt (wt_phase_nxt),
    .done      (wt_done),
    .we_n      (FLASH_WE_n)
  );

  // State register with registered strobe outputs
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      oe_n    <= 1'b1;
      dtack_n <= 1'b1;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      oe_n    <= oe_n_nxt;
      dtack_n <= dtack_n_nxt;
    end
  end

  // Next-state: write states track the WE timer's phase on the same edge
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    we_follow = wt_done ? AFTER_HOLD : phase_state(wt_phase_nxt);
    if (AS_CPU_n) begin
      state_nxt = ST_IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_hit) begin
            if (RW_n || !DS_n) state_nxt = ST_ACK;
          end else if (FLASH_ACCESS) begin
            if (RW_n) begin
              if (ws == '0) begin
                state_nxt = ST_ACK;
              end else begin
                state_nxt = ST_RWAIT;
                timer_nxt = ws - 1'b1;
              end
            end else if (!DS_n) begin
              state_nxt = we_start ? we_follow : ST_ACK;
            end
          end
        end
        ST_RWAIT: begin
          if (timer == '0) state_nxt = ST_ACK;
          else             timer_nxt = timer - 1'b1;
        end
        ST_WSETUP, ST_WPULSE, ST_WHOLD: state_nxt = we_follow;
        ST_WBUSY: begin
`ifdef FLASH_BUSY_WAIT_EN
          if (FLASH_BUSY_n) state_nxt = ST_ACK;
`else
          state_nxt = ST_ACK;
`endif
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output decode: OE falls only when a flash read is accepted from IDLE
  always_comb begin
    oe_n_nxt = oe_n;
    if (AS_CPU_n)
      oe_n_nxt = 1'b1;
    else if (state == ST_IDLE && !ctrl_hit && FLASH_ACCESS && RW_n)
      oe_n_nxt = 1'b0;
    dtack_n_nxt = (state_nxt != ST_ACK);
  end

  // Boot overlay: dropped by any write to the CIA page, restored only by reset
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n)
      ovl <= 1'b1;
    else if (!AS_CPU_n && !RW_n && A[23:16] == OVL_CLR_PAGE)
      ovl <= 1'b0;
  end

  // Control register: bank select and write unlock
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      bank   <= '0;
      unlock <= 1'b0;
    end else if (state == ST_IDLE && !AS_CPU_n && ctrl_hit && !RW_n && !DS_n) begin
      bank   <= D_HI[BANK_BITS-1:0];
      unlock <= D_HI[UNLOCK_BIT];
    end
  end

endmodule
